// File: rtl/keccak_sponge_ctrl.sv
// Keccak sponge controller: sequences absorb, padding, permutation and squeeze
// for SHAKE128/256 and SHA3-256/512 around an external Keccak-f datapath.
// Optional feature macro KECCAK_CTRL_XOF_EN: when defined, SHAKE output may
// span several rate blocks (re-permuting in SQUEEZE). When undefined, the SHAKE
// word count is clamped to one rate block.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. in_ready and out_valid are registered and depend only on state.
// in_valid/in_last and out_ready may change freely while the matching ready or
// valid is low. perm_start is a one-cycle pulse. The core answers with
// perm_done, which is honoured only while in PERM.
module keccak_sponge_ctrl #(
  parameter int W     = 64,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [LEN_W-1:0] out_len,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             absorb_en,
  output logic             pad_first,
  output logic             pad_last,
  output logic [5:0]       word_idx,
  output logic             perm_start,
  input  logic             perm_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ABSORB  = 3'd1,
    S_PAD     = 3'd2,
    S_PERM    = 3'd3,
    S_SQUEEZE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [5:0]       RATE_128 = 6'(1344 / W);
  localparam logic [5:0]       RATE_256 = 6'(1088 / W);
  localparam logic [5:0]       RATE_512 = 6'(576 / W);
  localparam logic [LEN_W-1:0] OUT_256  = LEN_W'(256 / W);
  localparam logic [LEN_W-1:0] OUT_512  = LEN_W'(512 / W);

  state_t           state_q, state_n;
  logic [5:0]       idx_q, idx_n;
  logic [5:0]       rate_q, rate_n;
  logic [LEN_W-1:0] remain_q, remain_n;
  logic             padded_q, padded_n;   // padding absorbed: next perm is final
  logic             pend_q, pend_n;       // in_last landed on R-1: pad block follows perm
  logic             pad_q;                // in PAD: datapath absorbs a padding word
  logic [5:0]       rate_sel;
  logic [LEN_W-1:0] total_sel;

  // Rate and total output length selected by the requested mode.
  always_comb begin
    rate_sel  = RATE_128;
    total_sel = out_len;
    case (mode)
      2'b00: rate_sel = RATE_128;
      2'b01: rate_sel = RATE_256;
      2'b10: rate_sel = RATE_256;
      default: rate_sel = RATE_512;
    endcase
    case (mode)
      2'b10: total_sel = OUT_256;
      2'b11: total_sel = OUT_512;
      default: begin
`ifdef KECCAK_CTRL_XOF_EN
        total_sel = out_len;
`else
        total_sel = (out_len < LEN_W'(rate_sel)) ? out_len : LEN_W'(rate_sel);
`endif
      end
    endcase
  end

  // Next-state and next-value logic for the sponge sequence.
  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    rate_n   = rate_q;
    remain_n = remain_q;
    padded_n = padded_q;
    pend_n   = pend_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_n  = S_ABSORB;
          idx_n    = 6'd0;
          rate_n   = rate_sel;
          remain_n = total_sel;
          padded_n = 1'b0;
          pend_n   = 1'b0;
        end
      end
      S_ABSORB: begin
        if (in_valid && in_ready) begin
          if (idx_q == rate_q - 6'd1) begin
            state_n = S_PERM;
            idx_n   = 6'd0;
            pend_n  = in_last;
          end else begin
            idx_n   = idx_q + 6'd1;
            state_n = in_last ? S_PAD : S_ABSORB;
          end
        end
      end
      S_PAD: begin
        if (idx_q == rate_q - 6'd1) begin
          state_n  = S_PERM;
          idx_n    = 6'd0;
          padded_n = 1'b1;
        end else begin
          idx_n = idx_q + 6'd1;
        end
      end
      S_PERM: begin
        if (perm_done) begin
          idx_n = 6'd0;
          if (pend_q) begin
            state_n = S_PAD;
            pend_n  = 1'b0;
          end else if (!padded_q) begin
            state_n = S_ABSORB;
          end else if (remain_q == '0) begin
            state_n = S_DONE;
          end else begin
            state_n = S_SQUEEZE;
          end
        end
      end
      S_SQUEEZE: begin
        if (out_valid && out_ready) begin
          remain_n = remain_q - LEN_W'(1);
          if (remain_q == LEN_W'(1)) begin
            state_n = S_DONE;
            idx_n   = 6'd0;
`ifdef KECCAK_CTRL_XOF_EN
          end else if (idx_q == rate_q - 6'd1) begin
            state_n = S_PERM;
            idx_n   = 6'd0;
`endif
          end else begin
            idx_n = idx_q + 6'd1;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        idx_n   = 6'd0;
      end
      default: begin
        state_n = S_IDLE;
        idx_n   = 6'd0;
      end
    endcase
  end

  // State register plus registered handshake/strobe outputs decoded from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      idx_q      <= 6'd0;
      rate_q     <= 6'd0;
      remain_q   <= '0;
      padded_q   <= 1'b0;
      pend_q     <= 1'b0;
      pad_q      <= 1'b0;
      in_ready   <= 1'b0;
      pad_first  <= 1'b0;
      pad_last   <= 1'b0;
      perm_start <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      rate_q     <= rate_n;
      remain_q   <= remain_n;
      padded_q   <= padded_n;
      pend_q     <= pend_n;
      pad_q      <= (state_n == S_PAD);
      in_ready   <= (state_n == S_ABSORB);
      pad_first  <= (state_n == S_PAD) && (state_q != S_PAD);
      pad_last   <= (state_n == S_PAD) && (idx_n == rate_n - 6'd1);
      perm_start <= (state_n == S_PERM) && (state_q != S_PERM);
      out_valid  <= (state_n == S_SQUEEZE);
      out_last   <= (state_n == S_SQUEEZE) && (remain_n == LEN_W'(1));
      busy       <= (state_n != S_IDLE);
      done       <= (state_n == S_DONE);
    end
  end

  // The XOR strobe follows the accepted message word in ABSORB, or every PAD cycle.
  assign absorb_en = (in_ready && in_valid) || pad_q;
  assign word_idx  = idx_q;
  assign state_dbg = state_q;

endmodule

// File: doc/keccak_sponge_ctrl.md
KECCAK_SPONGE_CTRL -- requirements
Module: keccak_sponge_ctrl

Interface
REQ-001 SHALL have parameter W, default 64, datapath word width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter LEN_W, default 16, width of the requested-output word count.
REQ-003 SHALL have port clk, input, 1 bit, the single clock.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port mode, input, 2 bits: 00 SHAKE128, 01 SHAKE256, 10 SHA3-256, 11 SHA3-512; sampled on accepted start.
REQ-006 SHALL have port start, input, 1 bit, begin a new hash; accepted only in IDLE.
REQ-007 SHALL have port out_len, input, LEN_W bits, number of output words requested for SHAKE; sampled on accepted start.
REQ-008 SHALL have ports in_valid/in_last (inputs, 1 bit) and in_ready (output, 1 bit), the message word handshake; in_last marks the final whole word.
REQ-009 SHALL have ports absorb_en, pad_first and pad_last (outputs, 1 bit each), the XOR strobe and the padding-word selects to the datapath.
REQ-010 SHALL have port word_idx, output, 6 bits, the current rate-word index.
REQ-011 SHALL have port perm_start (output, 1 bit) and port perm_done (input, 1 bit), the permutation-core handshake.
REQ-012 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_last (output, 1 bit), the squeeze handshake.
REQ-013 SHALL have ports busy and done, outputs, 1 bit each.

Function
REQ-014 SHALL set rate R in words to 1344/W, 1088/W, 1088/W or 576/W for mode 00, 01, 10 or 11.
REQ-015 SHALL set the total output word count to out_len for SHAKE, 256/W for SHA3-256 and 512/W for SHA3-512.
REQ-016 SHALL use the states IDLE, ABSORB, PAD, PERM, SQUEEZE and DONE.
REQ-017 SHALL move IDLE->ABSORB on start, clearing word_idx; start in any other state is ignored.
REQ-018 SHALL hold in_ready=1 only in ABSORB; each accepted word SHALL pulse absorb_en and increment word_idx.
REQ-019 SHALL go to PERM when a non-last word is accepted at word_idx=R-1.
REQ-020 SHALL go to PAD on accepted in_last; if that word was at R-1, PERM runs first and PAD then starts at word 0 of a fresh block.
REQ-021 SHALL, in PAD, write one padding word per cycle with absorb_en=1 from the next index to R-1: pad_first on the first such word, pad_last on word R-1, both together when only one padding word remains; then go to PERM.
REQ-022 SHALL pulse perm_start for exactly one cycle on entry to PERM and remain in PERM until perm_done=1.
REQ-023 SHALL, on perm_done, return to ABSORB if the message is unfinished, otherwise enter SQUEEZE with word_idx=0; for a zero-word request it SHALL enter DONE instead.
REQ-024 SHALL, in SQUEEZE, hold out_valid=1 and advance word_idx and the remaining count on each out_valid&&out_ready; out_last SHALL flag the final requested word.
REQ-025 SHALL enter PERM when the rate is exhausted in SQUEEZE with words remaining, returning to SQUEEZE at word_idx=0.
REQ-026 SHALL enter DONE after the final word; done=1 for one cycle, then IDLE; busy=1 in every state other than IDLE.
REQ-027 SHALL drive all handshake outputs as registered signals, valid in the cycle the state is entered.

Reset
REQ-028 SHALL, on rst=0 in any state including mid-permutation, enter IDLE immediately and drive word_idx, every strobe, busy and done to 0.
REQ-029 SHALL ignore a perm_done arriving after reset.

Configuration
REQ-030 SHALL, with KECCAK_CTRL_XOF_EN defined, support multi-block SHAKE squeeze per REQ-025.
REQ-031 SHALL, with KECCAK_CTRL_XOF_EN undefined, clamp the SHAKE word count to min(out_len,R) and never re-permute in SQUEEZE; SHA3 modes are unaffected.

Verification
REQ-032 SHALL test W=64, mode 10, 3 words with in_last on word 2: pad_first at idx 3, pad_last at idx 16, one perm_start, then 4 output words and out_last on the 4th.
REQ-033 SHALL test W=64, mode 11, 9 words with in_last at idx 8: PERM runs, then a PAD block idx 0..8 with pad_first at 0 and pad_last at 8, then a second PERM and 8 output words.
REQ-034 SHALL test W=64, mode 00, out_len=50, XOF_EN defined: 21+21+8 words across 3 squeeze perms; with XOF_EN undefined: 21 words.
REQ-035 SHALL test out_ready held low for 5 cycles mid-squeeze: out_valid stays 1 and word_idx stays stable.
REQ-036 SHALL test rst=0 while waiting in PERM, followed by a late perm_done: the block stays in IDLE with busy=0, and the next start completes correctly.
REQ-037 SHALL test W=32, mode 01, out_len=0: R=34, absorb/pad/perm occur, no out_valid is raised, and done pulses once.
